// File: rtl/tpm_pkg.sv
// Shared types and constants for the toggle period meter and its pin-input helpers.
package tpm_pkg;

   typedef enum logic {IDLE, ARMED} tpm_state_t;

   localparam int TPM_CNT_W_DEFAULT = 16;
   localparam int TPM_SYNC_STAGES   = 2;
   localparam int TPM_MIN_PERIOD    = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous pin input and flags its rising edges.
module sync_edge_detect
   import tpm_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic rise
);

   logic [TPM_SYNC_STAGES-1:0] sync_q;
   logic                       hist_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[TPM_SYNC_STAGES-2:0], sig_in};
         hist_q <= sync_q[TPM_SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[TPM_SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures the clk-cycle period between rising edges of an external toggle signal
// and publishes it byte-wise with sticky valid/overflow flags.
module toggle_period_meter
   import tpm_pkg::*;
#(
   parameter int CNT_W = TPM_CNT_W_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sig_in,
   input  logic       enable,
   input  logic       clear,
   input  logic       byte_sel,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       overflow,
   output logic       edge_pulse
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   tpm_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] period;
   logic [15:0]      period_w;
   logic             rise;

   sync_edge_detect u_sync (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .rise   (rise)
   );

   assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         period     <= '0;
         valid      <= 1'b0;
         overflow   <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         edge_pulse <= rise;

         if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (rise) state <= ARMED;
               end
               ARMED: begin
                  if (rise) cnt <= '0;
                  else      cnt <= cnt_inc;
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end

         // clear wins over any edge/saturation update; the counter restart above is unaffected
         if (clear) begin
            period   <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
         end else if (enable && state == ARMED) begin
            if (rise) begin
               period <= cnt_inc;
               valid  <= 1'b1;
            end else if (cnt == CNT_MAX) begin
               overflow <= 1'b1;
            end
         end
      end
   end

   assign period_w = 16'(period);

   always_comb begin
      data_out = period_w[7:0];
      if (byte_sel) data_out = period_w[15:8];
   end

endmodule

// File: tb/tb_toggle_period_meter.sv
// Bench for toggle_period_meter: vector table, directed corner sequences and a
// timestamp-based reference model checked every cycle on a 16-bit and a 9-bit instance.
module tb_toggle_period_meter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sig_in = 1'b0;
   logic       enable = 1'b1;
   logic       clear = 1'b0;
   logic       byte_sel = 1'b0;

   logic [7:0] data16, data9;
   logic       valid16, valid9, ovf16, ovf9, ep16, ep9;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   toggle_period_meter #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable), .clear(clear),
      .byte_sel(byte_sel), .data_out(data16), .valid(valid16), .overflow(ovf16),
      .edge_pulse(ep16)
   );

   toggle_period_meter #(.CNT_W(9)) dut9 (
      .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable), .clear(clear),
      .byte_sel(byte_sel), .data_out(data9), .valid(valid9), .overflow(ovf9),
      .edge_pulse(ep9)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: sampled-input history plus edge timestamps.
   bit          hq[$] = '{1'b0, 1'b0, 1'b0};
   int unsigned n_edge = 0;
   int unsigned last_m[2];
   int unsigned maxv[2] = '{65535, 511};
   logic [15:0] per_m[2] = '{16'd0, 16'd0};
   bit          arm_m[2], vld_m[2], ovf_m[2];
   bit          ep_m = 1'b0;

   always @(posedge clk) begin
      bit          rs;
      int unsigned gap;
      rs = hq[1] & ~hq[0];
      void'(hq.pop_front());
      hq.push_back(rst ? 1'b0 : sig_in);
      ep_m = rst ? 1'b0 : rs;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            arm_m[k] = 1'b0; per_m[k] = '0; vld_m[k] = 1'b0; ovf_m[k] = 1'b0;
         end else begin
            gap = n_edge - last_m[k];
            if (clear) begin
               per_m[k] = '0; vld_m[k] = 1'b0; ovf_m[k] = 1'b0;
            end else if (enable && arm_m[k]) begin
               if (rs) begin
                  per_m[k] = 16'((gap > maxv[k]) ? maxv[k] : gap);
                  vld_m[k] = 1'b1;
               end else if (gap > maxv[k]) begin
                  ovf_m[k] = 1'b1;
               end
            end
            if (!enable) arm_m[k] = 1'b0;
            else if (rs) begin
               arm_m[k]  = 1'b1;
               last_m[k] = n_edge;
            end
         end
      end
      n_edge++;
   end

   function automatic logic [7:0] sel_byte(input logic [15:0] p, input logic s);
      return s ? p[15:8] : p[7:0];
   endfunction

   always @(posedge clk) begin
      #2;
      chk("m_data16",  16'(data16),  16'(sel_byte(per_m[0], byte_sel)));
      chk("m_data9",   16'(data9),   16'(sel_byte(per_m[1], byte_sel)));
      chk("m_valid16", 16'(valid16), 16'(vld_m[0]));
      chk("m_valid9",  16'(valid9),  16'(vld_m[1]));
      chk("m_ovf16",   16'(ovf16),   16'(ovf_m[0]));
      chk("m_ovf9",    16'(ovf9),    16'(ovf_m[1]));
      chk("m_ep16",    16'(ep16),    16'(ep_m));
      chk("m_ep9",     16'(ep9),     16'(ep_m));
   end

   typedef struct {
      logic       rst, sig, en, clr, sel;
      logic [7:0] data;
      logic       vld, ovf, ep;
   } vec_t;

   vec_t tbl[12];

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sq(input int n);
      sig_in = 1'b1;
      hold(n / 2);
      sig_in = 1'b0;
      hold(n - n / 2);
   endtask

   task automatic wave(input int half, input int periods);
      for (int p = 0; p < periods; p++) begin
         int first;
         int hits;
         first = -1;
         hits  = 0;
         for (int i = 0; i < 2 * half; i++) begin
            @(negedge clk);
            sig_in = (i < half);
            @(posedge clk);
            #1;
            if (ep16) begin
               hits++;
               if (first < 0) first = i;
            end
         end
         chk("ep_latency", 16'(first), 16'd2);
         chk("ep_count",   16'(hits),  16'd1);
      end
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};

      // reset with toggling input, then clock/2 toggle
      for (int r = 0; r < 12; r++) begin
         @(negedge clk);
         rst = tbl[r].rst; sig_in = tbl[r].sig; enable = tbl[r].en;
         clear = tbl[r].clr; byte_sel = tbl[r].sel;
         @(posedge clk);
         #1;
         chk("tbl_data16",  16'(data16),  16'(tbl[r].data));
         chk("tbl_valid16", 16'(valid16), 16'(tbl[r].vld));
         chk("tbl_ovf16",   16'(ovf16),   16'(tbl[r].ovf));
         chk("tbl_ep16",    16'(ep16),    16'(tbl[r].ep));
         chk("tbl_data9",   16'(data9),   16'(tbl[r].data));
         chk("tbl_valid9",  16'(valid9),  16'(tbl[r].vld));
      end

      // period 300
      @(negedge clk);
      byte_sel = 1'b0;
      wave(150, 3);
      @(negedge clk);
      #1;
      chk("p300_lo",    16'(data16),  16'h2C);
      chk("p300_valid", 16'(valid16), 16'd1);
      byte_sel = 1'b1;
      #1;
      chk("p300_hi",    16'(data16),  16'h01);
      chk("p300_hi9",   16'(data9),   16'h01);

      // 600-cycle period saturates the 9-bit instance only
      wave(300, 2);
      @(negedge clk);
      byte_sel = 1'b0;
      #1;
      chk("ovf9",       16'(ovf9),   16'd1);
      chk("ovf16",      16'(ovf16),  16'd0);
      chk("sat9_lo",    16'(data9),  16'hFF);
      chk("p600_lo",    16'(data16), 16'h58);
      byte_sel = 1'b1;
      #1;
      chk("sat9_hi",    16'(data9),  16'h01);
      chk("p600_hi",    16'(data16), 16'h02);

      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      chk("clr_ovf9",   16'(ovf9),    16'd0);
      chk("clr_valid9", 16'(valid9),  16'd0);
      chk("clr_data9",  16'(data9),   16'd0);
      chk("clr_valid",  16'(valid16), 16'd0);
      @(negedge clk);
      clear    = 1'b0;
      enable   = 1'b0;
      byte_sel = 1'b0;

      // clear coincident with an edge
      hold(3);
      enable = 1'b1;
      hold(4);
      sq(40);
      sq(40);
      chk("p40",        16'(data16),  16'd40);
      chk("p40_valid",  16'(valid16), 16'd1);
      sig_in = 1'b1;
      hold(2);
      clear = 1'b1;
      @(posedge clk);
      #1;
      chk("cc_ep",      16'(ep16),    16'd1);
      chk("cc_valid",   16'(valid16), 16'd0);
      chk("cc_data",    16'(data16),  16'd0);
      chk("cc_valid9",  16'(valid9),  16'd0);
      @(negedge clk);
      clear = 1'b0;
      hold(22);
      sig_in = 1'b0;
      hold(25);
      sig_in = 1'b1;
      hold(4);
      chk("cc_p50",     16'(data16),  16'd50);
      chk("cc_valid50", 16'(valid16), 16'd1);
      chk("cc_p50_9",   16'(data9),   16'd50);
      sig_in = 1'b0;

      // enable dropped mid-period
      hold(10);
      enable = 1'b0;
      hold(5);
      chk("dis_keep",   16'(data16),  16'd50);
      chk("dis_valid",  16'(valid16), 16'd1);
      enable = 1'b1;
      hold(2);
      sq(30);
      chk("rearm_only", 16'(data16),  16'd50);
      sq(30);
      chk("rearm_p30",  16'(data16),  16'd30);

      // randomized traffic against the reference model
      begin
         int run;
         run = 0;
         for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (run == 0) begin
               sig_in = ~sig_in;
               run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 700))
                                                : int'($urandom_range(1, 6));
            end
            run--;
            enable   = ($urandom_range(0, 299) != 0);
            clear    = ($urandom_range(0, 249) == 0);
            byte_sel = 1'($urandom_range(0, 1));
         end
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
